// File: rtl/servo_pwm_decoder.sv
// Measures high time and rise-to-rise period of a servo PWM line and classifies the width.
// Result valid 3 clk after the falling edge; held until acked, new results dropped (overrun) when unacked.
module servo_pwm_decoder #(
  parameter int unsigned T0_TICKS  = 50000,
  parameter int unsigned T1_TICKS  = 73000,
  parameter int unsigned T2_TICKS  = 95000,
  parameter int unsigned T3_TICKS  = 100000,
  parameter int unsigned TOL_TICKS = 1000,
  parameter int unsigned MIN_PULSE = 25000,
  parameter int unsigned MAX_PULSE = 150000,
  parameter int unsigned TIMEOUT   = 3500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  input  logic        res_ack,
  output logic        res_valid,
  output logic [21:0] width_out,
  output logic [21:0] period_out,
  output logic [2:0]  class_out,
  output logic        overrun,
  output logic        stuck_high,
  output logic        idle,
  output logic        glitch
);

  localparam logic [21:0] MIN_P = 22'(MIN_PULSE);
  localparam logic [21:0] MAX_P = 22'(MAX_PULSE);
  localparam logic [21:0] TMO   = 22'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_WAIT_LOW, S_LOW} state_t;

  state_t      state;
  logic        s1, s2, s2_d;
  logic [1:0]  fill;
  logic        armed;
  logic [21:0] hi_cnt, per_cnt, lo_cnt, period_reg;
  logic        prev_ok;
  logic        rise, fall, new_res;
  logic [2:0]  cls;

  function automatic logic [21:0] sat_inc(input logic [21:0] v);
    return (v == '1) ? v : v + 22'd1;
  endfunction

  function automatic logic near(input logic [21:0] w, input int unsigned t);
    logic signed [23:0] d;
    d = $signed({2'b00, w}) - $signed(24'(t));
    return (d >= -$signed(24'(TOL_TICKS))) && (d <= $signed(24'(TOL_TICKS)));
  endfunction

  // A rise only counts once a genuine low has been seen after reset, so a
  // pulse already in progress at reset release is ignored until it falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s2_d  <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= pwm_in;
      s2    <= s1;
      s2_d  <= s2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~s2);
    end
  end

  assign rise    = armed & s2 & ~s2_d;
  assign fall    = ~s2 & s2_d;
  assign new_res = (state == S_HIGH) && fall && (hi_cnt >= MIN_P);

  always_comb begin
    cls = 3'd7;
    if      (near(hi_cnt, T0_TICKS)) cls = 3'd0;
    else if (near(hi_cnt, T1_TICKS)) cls = 3'd1;
    else if (near(hi_cnt, T2_TICKS)) cls = 3'd2;
    else if (near(hi_cnt, T3_TICKS)) cls = 3'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hi_cnt     <= '0;
      per_cnt    <= '0;
      lo_cnt     <= '0;
      period_reg <= '0;
      prev_ok    <= 1'b0;
      idle       <= 1'b1;
      glitch     <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          lo_cnt <= sat_inc(lo_cnt);
          if (lo_cnt > TMO) idle <= 1'b1;
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= 22'd1;
            per_cnt <= 22'd1;
            lo_cnt  <= '0;
            prev_ok <= 1'b0;
            idle    <= 1'b0;
          end
        end
        S_HIGH: begin
          per_cnt <= sat_inc(per_cnt);
          if (fall) begin
            state  <= S_LOW;
            lo_cnt <= '0;
            if (hi_cnt < MIN_P) glitch <= 1'b1;
          end else if (hi_cnt > MAX_P) begin
            state      <= S_WAIT_LOW;
            stuck_high <= 1'b1;
          end else begin
            hi_cnt <= sat_inc(hi_cnt);
          end
        end
        S_WAIT_LOW: begin
          if (fall) begin
            state  <= S_IDLE;
            lo_cnt <= '0;
          end
        end
        default: begin
          per_cnt <= sat_inc(per_cnt);
          lo_cnt  <= sat_inc(lo_cnt);
          if (rise) begin
            state      <= S_HIGH;
            period_reg <= per_cnt;
            prev_ok    <= 1'b1;
            hi_cnt     <= 22'd1;
            per_cnt    <= 22'd1;
            lo_cnt     <= '0;
          end else if (lo_cnt > TMO) begin
            state   <= S_IDLE;
            idle    <= 1'b1;
            prev_ok <= 1'b0;
          end
        end
      endcase
    end
  end

  // An ack in the same cycle as a new result frees the slot for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      width_out  <= '0;
      period_out <= '0;
      class_out  <= 3'd7;
      overrun    <= 1'b0;
    end else if (new_res) begin
      if (!res_valid || res_ack) begin
        res_valid  <= 1'b1;
        width_out  <= hi_cnt;
        period_out <= prev_ok ? period_reg : '0;
        class_out  <= cls;
      end else begin
        overrun <= 1'b1;
      end
    end else if (res_valid && res_ack) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Randomized and directed pulse trains against a pulse-level reference model of the decoder.
module tb_servo_pwm_decoder;
  localparam int T0 = 500, T1 = 730, T2 = 950, T3 = 1000, TOL = 10;
  localparam int MINP = 250, MAXP = 1500, TMO = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic        res_ack = 1'b0;
  logic        res_valid;
  logic [21:0] width_out, period_out;
  logic [2:0]  class_out;
  logic        overrun, stuck_high, idle, glitch;

  int errors = 0;
  int checks = 0;
  int have_prev = 0;
  int prev_len = 0;

  servo_pwm_decoder #(
    .T0_TICKS(T0), .T1_TICKS(T1), .T2_TICKS(T2), .T3_TICKS(T3), .TOL_TICKS(TOL),
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .res_ack(res_ack),
    .res_valid(res_valid), .width_out(width_out), .period_out(period_out),
    .class_out(class_out), .overrun(overrun), .stuck_high(stuck_high),
    .idle(idle), .glitch(glitch)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_class(input int w);
    int tg[4];
    int c;
    tg = '{T0, T1, T2, T3};
    c = 7;
    for (int i = 3; i >= 0; i--) begin
      if (((w - tg[i]) <= TOL) && ((tg[i] - w) <= TOL)) c = i;
    end
    return c;
  endfunction

  // Model bookkeeping for a completed pulse of n high and l low cycles.
  task automatic model_update(input int n, input int l);
    if (n > MAXP || l > TMO) begin
      have_prev = 0;
    end else begin
      have_prev = 1;
      prev_len  = n + l;
    end
  endtask

  // Entered and left just after a negedge. ack_dly < 0 leaves the result unacked.
  task automatic pulse(input int n, input int l, input int ack_dly);
    int  exp_per, exp_cls, seen_at;
    bit  exp_res;
    exp_res = (n >= MINP) && (n <= MAXP);
    exp_per = have_prev ? prev_len : 0;
    exp_cls = ref_class(n);
    seen_at = 0;
    pwm_in = 1'b1;
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    for (int i = 1; i <= l; i++) begin
      @(negedge clk);
      res_ack = 1'b0;
      if (res_valid && seen_at == 0) begin
        seen_at = i;
        check("latency", i, 3);
        check("width", int'(width_out), n);
        check("period", int'(period_out), exp_per);
        check("class", int'(class_out), exp_cls);
      end
      if (seen_at != 0 && ack_dly >= 0) begin
        if (i == seen_at + ack_dly) res_ack = 1'b1;
        if (i == seen_at + ack_dly + 1) check("ack_clear", int'(res_valid), 0);
      end
    end
    check("result_seen", int'(seen_at != 0), int'(exp_res));
    if (n < MINP) check("glitch_flag", int'(glitch), 1);
    if (n > MAXP) check("stuck_flag", int'(stuck_high), 1);
    model_update(n, l);
  endtask

  task automatic check_reset_vals();
    check("rst_valid", int'(res_valid), 0);
    check("rst_width", int'(width_out), 0);
    check("rst_period", int'(period_out), 0);
    check("rst_class", int'(class_out), 7);
    check("rst_flags", int'({overrun, stuck_high, glitch}), 0);
    check("rst_idle", int'(idle), 1);
  endtask

  initial begin
    int n, l, sel;
    int tg[4];
    tg = '{T0, T1, T2, T3};
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Steady 73000-equivalent pulses
    for (int k = 0; k < 3; k++) pulse(730, 2000 - 730, 2);
    check("idle_live", int'(idle), 0);

    // Width sweep around the match windows
    pulse(490, 1500, 1);
    pulse(511, 1500, 1);
    pulse(940, 1500, 1);
    pulse(1010, 1500, 1);

    // Glitch, then a pulse whose period starts at the glitch rise
    pulse(100, 900, 2);
    pulse(500, 1500, 2);

    // Stuck high, then period restarts from zero
    pulse(2000, 800, 2);
    pulse(730, 1500, 2);

    // Ack landing on the same edge as the second result
    pulse(730, 800, -1);
    pwm_in = 1'b1;
    repeat (600) @(negedge clk);
    pwm_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("sameack_valid", int'(res_valid), 1);
    check("sameack_width", int'(width_out), 600);
    check("sameack_period", int'(period_out), 730 + 800);
    check("sameack_overrun", int'(overrun), 0);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("sameack_clear", int'(res_valid), 0);
    repeat (496) @(negedge clk);
    model_update(600, 500);

    // Unacked result followed by a second pulse: first retained, overrun set
    pulse(730, 800, -1);
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (799) @(negedge clk);
    check("ovr_valid", int'(res_valid), 1);
    check("ovr_width", int'(width_out), 730);
    check("ovr_flag", int'(overrun), 1);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("ovr_clear", int'(res_valid), 0);
    model_update(500, 800);

    // Randomized pulses
    for (int k = 0; k < 10; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        1:       n = tg[$urandom_range(0, 3)] + $urandom_range(0, 30) - 15;
        2:       n = $urandom_range(20, MINP - 10);
        default: n = $urandom_range(MINP + 10, MAXP - 100);
      endcase
      l = $urandom_range(300, 1500);
      pulse(n, l, $urandom_range(0, 5));
    end

    // Line goes quiet past the timeout
    pulse(730, TMO + 1000, 2);
    check("idle_timeout", int'(idle), 1);
    pulse(500, 1500, 2);

    // Reset in the middle of a high
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    pwm_in = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid) n = 1;
    end
    check("rst_pulse_ignored", n, 0);
    have_prev = 0;
    pulse(500, 1500, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
